fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage MIPS pipeline.
- Tracks destination registers of the instructions in EX, MEM, WB and the one retired last cycle (WB2).
- Generates the 2-bit operand-select codes that drive the EX-stage 4:1 operand muxes.
- Detects load-use hazards and requests a one-cycle ID stall with a bubble into EX.

---
 rtl/fwd_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
// Tracks destination registers in EX/MEM/WB/WB2 and drives the EX operand-mux selects.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              ex_is_bubble
);

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_WB    = 2'b01,
    SEL_EXMEM = 2'b10,
    SEL_WB2   = 2'b11
  } fwd_sel_e;

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic [REG_AW-1:0] ex_rd_q, ex_rs_q, ex_rt_q;
  logic [REG_AW-1:0] ex_rd_d, ex_rs_d, ex_rt_d;
  logic              ex_we_q, ex_ld_q, ex_use_rs_q, ex_use_rt_q;
  logic              ex_we_d, ex_ld_d, ex_use_rs_d, ex_use_rt_d;
  logic [REG_AW-1:0] mem_rd_q, wb_rd_q, wb2_rd_q;
  logic              mem_we_q, mem_ld_q, wb_we_q, wb2_we_q;
  logic              id_take;
  fwd_sel_e          sel_a, sel_b;

  assign stall = id_valid && ex_ld_q && ex_we_q && (ex_rd_q != ZR) &&
                 ((id_use_rs && (id_rs == ex_rd_q)) || (id_use_rt && (id_rt == ex_rd_q)));

  assign id_take = id_valid && !stall && !flush;

  // Register addresses follow ID unconditionally; only the control bits mark a bubble.
  always_comb begin
    ex_rd_d     = id_rd;
    ex_rs_d     = id_rs;
    ex_rt_d     = id_rt;
    ex_we_d     = id_take && id_reg_write;
    ex_ld_d     = id_take && id_mem_read;
    ex_use_rs_d = id_take && id_use_rs;
    ex_use_rt_d = id_take && id_use_rt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q     <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_ld_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      wb2_rd_q    <= '0;
      wb2_we_q    <= 1'b0;
    end else if (!hold) begin
      wb2_rd_q    <= wb_rd_q;
      wb2_we_q    <= wb_we_q;
      wb_rd_q     <= mem_rd_q;
      wb_we_q     <= mem_we_q;
      mem_rd_q    <= ex_rd_q;
      mem_we_q    <= ex_we_q;
      mem_ld_q    <= ex_ld_q;
      ex_rd_q     <= ex_rd_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_we_q     <= ex_we_d;
      ex_ld_q     <= ex_ld_d;
      ex_use_rs_q <= ex_use_rs_d;
      ex_use_rt_q <= ex_use_rt_d;
    end
  end

  // Youngest producer wins; a load sitting in MEM has no data yet, so it never matches as EX/MEM.
  always_comb begin
    sel_a = SEL_RF;
    if (ex_use_rs_q && (ex_rs_q != ZR)) begin
      if (mem_we_q && !mem_ld_q && (mem_rd_q == ex_rs_q)) sel_a = SEL_EXMEM;
      else if (wb_we_q && (wb_rd_q == ex_rs_q))           sel_a = SEL_WB;
      else if (wb2_we_q && (wb2_rd_q == ex_rs_q))         sel_a = SEL_WB2;
    end
  end

  always_comb begin
    sel_b = SEL_RF;
    if (ex_use_rt_q && (ex_rt_q != ZR)) begin
      if (mem_we_q && !mem_ld_q && (mem_rd_q == ex_rt_q)) sel_b = SEL_EXMEM;
      else if (wb_we_q && (wb_rd_q == ex_rt_q))           sel_b = SEL_WB;
      else if (wb2_we_q && (wb2_rd_q == ex_rt_q))         sel_b = SEL_WB2;
    end
  end

  assign fwd_a_sel    = sel_a;
  assign fwd_b_sel    = sel_b;
  assign ex_is_bubble = !(ex_we_q || ex_use_rs_q || ex_use_rt_q);

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus random traffic
// compared against a slot-array reference of the pipeline.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, ex_is_bubble;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .ex_is_bubble(ex_is_bubble)
  );

  // Reference: slot 0 = EX, 1 = MEM, 2 = WB, 3 = WB2 (older instructions at higher index).
  typedef struct {
    logic [4:0] rd, rs, rt;
    bit         we, ld, urs, urt;
  } slot_t;
  slot_t m[4];
  logic [1:0] age_code[1:3];

  function automatic slot_t bubble();
    slot_t s;
    s.rd = '0; s.rs = '0; s.rt = '0;
    s.we = 0; s.ld = 0; s.urs = 0; s.urt = 0;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = bubble();
  endtask

  function automatic logic [1:0] m_fwd(bit used, logic [4:0] src);
    if (!used || src == 5'd0) return 2'b00;
    for (int i = 1; i <= 3; i++)
      if (m[i].we && m[i].rd == src && !(i == 1 && m[i].ld)) return age_code[i];
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    return id_valid && m[0].ld && m[0].we && m[0].rd != 5'd0 &&
           ((id_use_rs && id_rs == m[0].rd) || (id_use_rt && id_rt == m[0].rd));
  endfunction

  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("fwd_a", fwd_a_sel, m_fwd(m[0].urs, m[0].rs));
    chk("fwd_b", fwd_b_sel, m_fwd(m[0].urt, m[0].rt));
    chk("stall", {1'b0, stall}, {1'b0, m_stall()});
    chk("bubble", {1'b0, ex_is_bubble}, {1'b0, !(m[0].we || m[0].urs || m[0].urt)});
  endtask

  task automatic tick();
    bit st;
    slot_t s;
    st = m_stall();
    @(posedge clk);
    if (!hold) begin
      m[3] = m[2]; m[2] = m[1]; m[1] = m[0];
      if (id_valid && !st && !flush) begin
        s.rd = id_rd; s.rs = id_rs; s.rt = id_rt;
        s.we = id_reg_write; s.ld = id_mem_read; s.urs = id_use_rs; s.urt = id_use_rt;
        m[0] = s;
      end else m[0] = bubble();
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    #1;
    check_model();
    tick();
  endtask

  task automatic drv(bit v, logic [4:0] rs, logic [4:0] rt, bit urs, bit urt,
                     logic [4:0] rd, bit we, bit ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_reg_write = we; id_mem_read = ld;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 4; i++) cyc();
  endtask

  initial begin
    age_code[1] = 2'b10; age_code[2] = 2'b01; age_code[3] = 2'b11;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_a", fwd_a_sel, 2'b00);
    chk("rst_b", fwd_b_sel, 2'b00);
    chk("rst_stall", {1'b0, stall}, 2'b00);
    chk("rst_bubble", {1'b0, ex_is_bubble}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    drain();

    // add $3,$1,$2 ; sub $4,$3,$5
    drv(1, 1, 2, 1, 1, 3, 1, 0); cyc();
    drv(1, 3, 5, 1, 1, 4, 1, 0); cyc();
    nop(); #1;
    chk("exmem_a", fwd_a_sel, 2'b10); chk("exmem_b", fwd_b_sel, 2'b00);
    chk("exmem_stall", {1'b0, stall}, 2'b00);
    cyc(); drain();

    // lw $3 ; add $4,$3,$3 -> one stall cycle, then 01/01
    drv(1, 1, 0, 1, 0, 3, 1, 1); cyc();
    drv(1, 3, 3, 1, 1, 4, 1, 0); #1;
    chk("lu_stall1", {1'b0, stall}, 2'b01);
    cyc(); #1;
    chk("lu_stall2", {1'b0, stall}, 2'b00);
    chk("lu_bubble", {1'b0, ex_is_bubble}, 2'b01);
    cyc(); nop(); #1;
    chk("lu_a", fwd_a_sel, 2'b01); chk("lu_b", fwd_b_sel, 2'b01);
    cyc(); drain();

    // add $3 / nop / nop / or $5,$3,$0 -> 11 ; with three nops -> 00
    drv(1, 1, 2, 1, 1, 3, 1, 0); cyc();
    nop(); cyc(); cyc();
    drv(1, 3, 0, 1, 1, 5, 1, 0); cyc();
    nop(); #1;
    chk("wb2_a", fwd_a_sel, 2'b11); chk("wb2_b", fwd_b_sel, 2'b00);
    cyc(); drain();
    drv(1, 1, 2, 1, 1, 3, 1, 0); cyc();
    nop(); cyc(); cyc(); cyc();
    drv(1, 3, 0, 1, 1, 5, 1, 0); cyc();
    nop(); #1;
    chk("old_a", fwd_a_sel, 2'b00);
    cyc(); drain();

    // add $3 ; add $3 ; sub $4,$3,$3 -> youngest wins
    drv(1, 1, 2, 1, 1, 3, 1, 0); cyc();
    drv(1, 2, 1, 1, 1, 3, 1, 0); cyc();
    drv(1, 3, 3, 1, 1, 4, 1, 0); cyc();
    nop(); #1;
    chk("young_a", fwd_a_sel, 2'b10); chk("young_b", fwd_b_sel, 2'b10);
    cyc(); drain();

    // lw $0 ; read $0 -> no stall, no forward
    drv(1, 1, 0, 1, 0, 0, 1, 1); cyc();
    drv(1, 0, 0, 1, 1, 4, 1, 0); #1;
    chk("zero_stall", {1'b0, stall}, 2'b00);
    cyc(); nop(); #1;
    chk("zero_a", fwd_a_sel, 2'b00); chk("zero_b", fwd_b_sel, 2'b00);
    cyc(); drain();

    // lw $3 in EX, flush with dependent in ID -> bubble, stall still visible
    drv(1, 1, 0, 1, 0, 3, 1, 1); cyc();
    drv(1, 3, 2, 1, 1, 4, 1, 0); flush = 1'b1; #1;
    chk("fl_stall", {1'b0, stall}, 2'b01);
    cyc(); flush = 1'b0; nop(); #1;
    chk("fl_bubble", {1'b0, ex_is_bubble}, 2'b01);
    cyc(); drain();

    // hold for three cycles while a forward is pending
    drv(1, 1, 2, 1, 1, 3, 1, 0); cyc();
    drv(1, 5, 3, 1, 1, 4, 1, 0); cyc();
    nop(); hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("hold_b", fwd_b_sel, 2'b10); chk("hold_a", fwd_a_sel, 2'b00);
      cyc();
    end
    hold = 1'b0; drain();

    // asynchronous reset mid-stream
    drv(1, 1, 2, 1, 1, 3, 1, 0); cyc();
    drv(1, 3, 3, 1, 1, 4, 1, 0); cyc();
    nop(); #2;
    rst_n = 1'b0; model_reset(); #1;
    chk("mrst_a", fwd_a_sel, 2'b00); chk("mrst_b", fwd_b_sel, 2'b00);
    chk("mrst_stall", {1'b0, stall}, 2'b00);
    chk("mrst_bubble", {1'b0, ex_is_bubble}, 2'b01);
    @(negedge clk); rst_n = 1'b1;
    drv(1, 3, 3, 1, 1, 4, 1, 0); cyc();
    nop(); #1;
    chk("post_rst_a", fwd_a_sel, 2'b00);
    cyc();

    // random traffic over a small register set to provoke frequent matches
    for (int n = 0; n < 400; n++) begin
      drv($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      hold  = $urandom_range(0, 7) == 0;
      flush = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 99) == 0) begin
        #1; rst_n = 1'b0; model_reset(); #1;
        check_model();
        rst_n = 1'b1;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
